seq_trigger_conditioner: RTL
============================

# seq_trigger_conditioner

Conditions the two asynchronous Arduino trigger pins (Mach-Zehnder and Rabi) into clean, single-cycle start pulses for the downstream RF pulse sequencer. It handles synchronisation, debouncing, rising-edge detection and priority arbitration, and holds off new triggers while the sequencer is busy. Rejected triggers are counted so firmware can detect dropped shots. It sits between the board trigger pins and the RF sequencer's start inputs.

## Interface
- SYNC_STAGES, 2, synchroniser depth per trigger input (≥2)
- DEBOUNCE, 333, consecutive cycles a new level must persist before acceptance (5 µs at 66.6 MHz, ≥1)
- HOLDOFF, 33300, dead cycles after each emitted start (500 µs); 0 = no holdoff
- OVR_W, 8, overrun counter width

- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- mz_trig_in  in  1  raw MZ trigger pin, asynchronous
- rabi_trig_in  in  1  raw Rabi trigger pin, asynchronous
- seq_busy  in  1  downstream sequencer running; no start may be issued while high
- mz_start  out  1  one-cycle MZ sequence start
- rabi_start  out  1  one-cycle Rabi sequence start
- pending  out  1  a trigger is latched, waiting for seq_busy low
- holdoff_active  out  1  block is in HOLD
- overrun_cnt  out  OVR_W  dropped-trigger count, saturating

## Operation
- Reset: all synchroniser flops, debounced levels, counters, pending slot and outputs go to 0; FSM goes to IDLE. An input already high when reset is released is treated as a fresh rising edge once it has been debounced.
- Synchroniser: each input passes through SYNC_STAGES flops.
- Debounce, per channel:
  - Debounced level `deb` (reset 0) and a counter.
  - The counter increments while sync ≠ deb and clears while sync = deb.
  - When the counter reaches DEBOUNCE−1 with sync still ≠ deb: deb ← sync and the counter clears.
  - A glitch shorter than DEBOUNCE cycles never changes deb.
- Event: a one-cycle `ev` is asserted on each 0→1 transition of deb. Falling edges produce nothing.
- Simultaneous mz_ev and rabi_ev in the same cycle: MZ wins; the Rabi event is dropped and counted as an overrun.
- FSM (IDLE, PEND, HOLD):
  - IDLE, event present, seq_busy=0: assert the winning start on the next cycle (registered); go to HOLD.
  - IDLE, event present, seq_busy=1: store the channel in the pending slot; pending=1; go to PEND.
  - PEND, seq_busy=0: assert the stored start on the next cycle; clear pending; go to HOLD.
  - PEND, any new event: drop it and increment overrun_cnt. The slot keeps the first event.
  - HOLD: count HOLDOFF cycles, starting on the cycle the start pulse is high, then return to IDLE. Events arriving in HOLD are dropped and counted. With HOLDOFF=0, HOLD lasts exactly one cycle.
- overrun_cnt saturates at 2^OVR_W−1 and clears only on rst. Two drops in the same cycle add 2, subject to saturation.
- mz_start and rabi_start are never high in the same cycle, and each pulse is exactly one cycle wide.
- Asserting rst mid-sequence immediately clears any pending trigger and any start pulse. No start is emitted after reset for an event that occurred before reset.

## Timing
- Latency, raw rising edge held stable to start high, with seq_busy=0 in IDLE: SYNC_STAGES + DEBOUNCE + 2 cycles (default 337).
- Latency, seq_busy falling to start high in PEND: 2 cycles (1 cycle to sample the registered busy, 1 output register).
- Minimum spacing between consecutive starts: HOLDOFF+1 cycles.
- pending and holdoff_active are registered and change on the same edge as the FSM state.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Clean trigger: mz_trig_in held high for 1000 cycles, seq_busy=0 → mz_start high for exactly 1 cycle, 337 cycles after the first sampled-high edge; rabi_start stays 0; overrun_cnt=0.
- Glitch rejection: rabi_trig_in pulsed high for 332 cycles, then low → no rabi_start. Repeat with a 333-cycle pulse → exactly one rabi_start.
- Busy deferral: seq_busy=1, MZ trigger debounced → pending=1 and no start. Drop seq_busy at cycle T → mz_start at T+2 and pending=0 at the same edge.
- Simultaneous triggers: both inputs rise on the same edge → only mz_start fires; overrun_cnt=1.
- Holdoff and saturation: with HOLDOFF=100 and OVR_W=2, 5 Rabi triggers spaced 400 cycles apart (so each is debounced) during PEND or HOLD → overrun_cnt saturates at 3. The next trigger after HOLD expires → a start fires.
- Reset mid-operation: assert rst while pending=1 → all outputs are 0 within the same cycle; release rst with inputs low → no start is ever emitted.

Source files
------------

// File: rtl/seq_trigger_conditioner.sv
// Turns the asynchronous MZ and Rabi trigger pins into one-cycle sequencer starts.
// The path is: synchronise, debounce, rising-edge detect, arbitrate (MZ wins), then hold-off FSM.
//
// state | meaning
// IDLE  | waiting for a trigger event
// PEND  | one trigger latched in the slot, waiting for seq_busy to drop
// HOLD  | start emitted, dead time running; new events are dropped and counted
module seq_trigger_conditioner #(
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 333,
   parameter int HOLDOFF     = 33300,
   parameter int OVR_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mz_trig_in,
   input  logic             rabi_trig_in,
   input  logic             seq_busy,
   output logic             mz_start,
   output logic             rabi_start,
   output logic             pending,
   output logic             holdoff_active,
   output logic [OVR_W-1:0] overrun_cnt
);

   localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int TW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [TW-1:0] T_LOAD = (HOLDOFF > 0) ? TW'(HOLDOFF - 1) : '0;

   typedef enum logic [1:0] {IDLE, PEND, HOLD} state_t;

   logic [1:0] trig_raw;
   logic [1:0] ev;
   assign trig_raw = {rabi_trig_in, mz_trig_in};

   for (genvar c = 0; c < 2; c++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_sr;
      logic                   sync_out;
      logic                   deb;
      logic                   deb_d1;
      logic                   ev_r;
      logic [DW-1:0]          dcnt;

      assign sync_out = sync_sr[SYNC_STAGES-1];
      assign ev[c]    = ev_r;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync_sr <= '0;
            deb     <= 1'b0;
            deb_d1  <= 1'b0;
            ev_r    <= 1'b0;
            dcnt    <= '0;
         end else begin
            sync_sr <= {sync_sr[SYNC_STAGES-2:0], trig_raw[c]};
            deb_d1  <= deb;
            ev_r    <= deb & ~deb_d1;
            if (sync_out != deb) begin
               if (dcnt == DW'(DEBOUNCE - 1)) begin
                  deb  <= sync_out;
                  dcnt <= '0;
               end else begin
                  dcnt <= dcnt + DW'(1);
               end
            end else begin
               dcnt <= '0;
            end
         end
      end
   end

   // Registered arbitration: MZ wins a tie, the losing Rabi event becomes a drop.
   logic arb_mz_q, arb_rabi_q, arb_drop_q, busy_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arb_mz_q   <= 1'b0;
         arb_rabi_q <= 1'b0;
         arb_drop_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         arb_mz_q   <= ev[0];
         arb_rabi_q <= ev[1] & ~ev[0];
         arb_drop_q <= ev[0] & ev[1];
         busy_q     <= seq_busy;
      end
   end

   state_t           state_q, state_d;
   logic             slot_q, slot_d;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic             mz_d, rabi_d, evt;
   logic [1:0]       drop_n;
   logic [OVR_W:0]   ovr_sum;
   logic [OVR_W-1:0] ovr_d;

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      tmr_d   = tmr_q;
      mz_d    = 1'b0;
      rabi_d  = 1'b0;
      drop_n  = {1'b0, arb_drop_q};
      evt     = arb_mz_q | arb_rabi_q;
      case (state_q)
         IDLE: begin
            if (evt) begin
               if (!busy_q) begin
                  mz_d    = arb_mz_q;
                  rabi_d  = arb_rabi_q;
                  tmr_d   = T_LOAD;
                  state_d = HOLD;
               end else begin
                  slot_d  = arb_rabi_q;
                  state_d = PEND;
               end
            end
         end
         PEND: begin
            if (evt) drop_n = drop_n + 2'd1;
            if (!busy_q) begin
               mz_d    = ~slot_q;
               rabi_d  = slot_q;
               tmr_d   = T_LOAD;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (evt) drop_n = drop_n + 2'd1;
            if (tmr_q == '0) state_d = IDLE;
            else             tmr_d   = tmr_q - TW'(1);
         end
         default: state_d = IDLE;
      endcase
      ovr_sum = {1'b0, overrun_cnt} + (OVR_W+1)'(drop_n);
      ovr_d   = ovr_sum[OVR_W] ? '1 : ovr_sum[OVR_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         slot_q         <= 1'b0;
         tmr_q          <= '0;
         mz_start       <= 1'b0;
         rabi_start     <= 1'b0;
         pending        <= 1'b0;
         holdoff_active <= 1'b0;
         overrun_cnt    <= '0;
      end else begin
         state_q        <= state_d;
         slot_q         <= slot_d;
         tmr_q          <= tmr_d;
         mz_start       <= mz_d;
         rabi_start     <= rabi_d;
         pending        <= (state_d == PEND);
         holdoff_active <= (state_d == HOLD);
         overrun_cnt    <= ovr_d;
      end
   end

endmodule
